hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Sequences pipeline stalls and flushes for the 5-stage MIPS pipeline. Detects load-use hazards,
//  holds the front end while a multi-cycle mul/div occupies EX, and flushes wrong-path instructions
//  on a taken branch/jump. Drives the noop input of the ID-stage control mux and the PC/IF-ID/ID-EX write enables.
// PARAMETERS
//  LD_STALL  1  bubbles inserted per load-use hazard (>=1)
//  MD_LAT    4  total cycles a mul/div op occupies EX (>=1; 1 = no hold)
// PORTS
//  Clk             in   1  pipeline clock
//  Reset           in   1  synchronous, active-high reset
//  id_rs           in   5  rs field of the instruction in ID
//  id_rt           in   5  rt field of the instruction in ID
//  id_uses_rt      in   1  instruction in ID reads rt as a source
//  id_md_start     in   1  instruction in ID is a multi-cycle mul/div
//  ex_memread      in   1  instruction in EX is a load
//  ex_rt           in   5  destination register of the load in EX
//  ex_branch_taken in   1  branch/jump resolved taken in EX
//  noop            out  1  to the control mux: zero the ID control word entering EX
//  pc_write        out  1  PC register write enable
//  ifid_write      out  1  IF/ID register write enable
//  ifid_flush      out  1  clear IF/ID to a nop
//  idex_write      out  1  ID/EX register write enable
//  state           out  2  current FSM state (debug)
// BEHAVIOUR
//  - One clock Clk; Reset synchronous active-high. On Reset: state=RUN, cnt=0; while Reset is high,
//    outputs are forced to noop=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_write=1.
//  - Outputs are combinational from state + current inputs (zero-latency); state/cnt are registered.
//  - lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//  - States: RUN=0, LDSTALL=1, MDBUSY=2 (3 unused -> RUN next cycle, outputs as RUN-default).
//  - RUN, priority high->low:
//    1. ex_branch_taken: noop=1, ifid_flush=1, pc_write=1, ifid_write=1, idex_write=1; lu and
//       id_md_start ignored; stay RUN.
//    2. lu: noop=1, pc_write=0, ifid_write=0, idex_write=1; if LD_STALL>1 -> LDSTALL, cnt=LD_STALL-1.
//    3. id_md_start: op issues normally (all enables 1, noop=0); if MD_LAT>1 -> MDBUSY, cnt=MD_LAT-1.
//    4. else: noop=0, pc_write=ifid_write=idex_write=1, ifid_flush=0.
//  - LDSTALL: noop=1, pc_write=0, ifid_write=0, idex_write=1; cnt--; cnt==1 -> RUN.
//  - MDBUSY: pc_write=0, ifid_write=0, idex_write=0 (EX holds mul/div), noop=0; cnt--; cnt==1 -> RUN.
//  - ex_branch_taken, lu and id_md_start are ignored in LDSTALL/MDBUSY (EX holds a bubble or mul/div).
//  - Reset mid-stall aborts immediately; the first post-reset cycle is RUN.
//  - cnt width = $clog2(max(LD_STALL,MD_LAT)+1); never wraps (loaded >=1, exits at 1).
// CONFIGURATION
//  HAZARD_PERF_EN defined: extra ports stall_cycles out 32 (+1 per cycle with pc_write=0, Reset
//   low) and flush_count out 32 (+1 per RUN cycle taking priority 1); both wrap, cleared by Reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  hazard_pkg: state encodings RUN/LDSTALL/MDBUSY, REG_ZERO=5'd0, PERF_W=32.
//  Sub-module hazard_stall_cnt: loadable down-counter (load, value, dec, is_one); FSM in the top.
// TESTING
//  1. lw $t0 in EX (ex_rt=8), ID add rs=8, LD_STALL=1 -> one cycle noop=1, pc_write=0; next RUN.
//  2. LD_STALL=2, same hazard -> two consecutive stall cycles, state RUN->LDSTALL->RUN.
//  3. lu and ex_branch_taken same cycle -> ifid_flush=1, noop=1, pc_write=1, state stays RUN.
//  4. id_md_start, MD_LAT=4 -> issue cycle, then 3 cycles idex_write=0, pc_write=0; back to RUN.
//  5. ex_rt=0 with ex_memread, id_rs=0 -> no stall; Reset asserted in MDBUSY -> RUN next cycle.
//  6. HAZARD_PERF_EN: scenarios 1+4 -> stall_cycles=4; scenario 3 -> flush_count=1.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and widths for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDBUSY  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PERF_W   = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID/EX hazard inputs and stall/flush enables between the pipeline and the controller.
interface hazard_stall_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_md_start;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       noop;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_md_start, ex_memread, ex_rt, ex_branch_taken,
    input  noop, pc_write, ifid_write, ifid_flush, idex_write, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_md_start, ex_memread, ex_rt, ex_branch_taken,
    output noop, pc_write, ifid_write, ifid_flush, idex_write, state
  );
endinterface

// File: rtl/hazard_stall_ctrl_cnt.sv
// Loadable down-counter timing the remaining cycles of a stall; saturates at zero.
module hazard_stall_cnt #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         is_one
);
  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset)                   cnt <= '0;
    else if (load)               cnt <= value;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign is_one = (cnt == W'(1));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mul-div / branch-flush stall sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds stall_cycles and flush_count performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int LD_STALL = 1,
  parameter int MD_LAT   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic [PERF_W-1:0]   flush_count
`endif
);
  localparam int CW = $clog2(max2(LD_STALL, MD_LAT) + 1);

  state_t        state_q, state_d;
  logic          lu, cnt_load, cnt_dec, cnt_one;
  logic [CW-1:0] cnt_val;

  assign lu = bus.ex_memread && (bus.ex_rt != REG_ZERO) &&
              ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));

  hazard_stall_cnt #(.W(CW)) u_cnt (
    .Clk    (Clk),
    .Reset  (Reset),
    .load   (cnt_load),
    .value  (cnt_val),
    .dec    (cnt_dec),
    .is_one (cnt_one)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.noop        = 1'b0;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_write  = 1'b1;
    cnt_load        = 1'b0;
    cnt_val         = '0;
    cnt_dec         = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          bus.noop       = 1'b1;
          bus.ifid_flush = 1'b1;
        end else if (lu) begin
          bus.noop       = 1'b1;
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          if (LD_STALL > 1) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(LD_STALL - 1);
            state_d  = LDSTALL;
          end
        end else if (bus.id_md_start) begin
          if (MD_LAT > 1) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(MD_LAT - 1);
            state_d  = MDBUSY;
          end
        end
      end
      LDSTALL: begin
        bus.noop       = 1'b1;
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        cnt_dec        = 1'b1;
        if (cnt_one) state_d = RUN;
      end
      MDBUSY: begin
        // EX keeps the mul/div, so ID/EX must not be overwritten either.
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.idex_write = 1'b0;
        cnt_dec        = 1'b1;
        if (cnt_one) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (Reset) begin
      bus.noop       = 1'b1;
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_write = 1'b1;
    end
  end

  assign bus.state = state_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!bus.pc_write) stall_cycles <= stall_cycles + 1'b1;
      if (state_q == RUN && bus.ex_branch_taken) flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed checks of hazard_stall_ctrl with LD_STALL=1 (d1) and LD_STALL=2 (d2), MD_LAT=4.
module tb_hazard_stall_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl_if ifa ();
  hazard_stall_ctrl_if ifb ();

`ifdef HAZARD_PERF_EN
  logic [31:0] sc1, fc1, sc2, fc2;
`endif

  hazard_stall_ctrl #(.LD_STALL(1), .MD_LAT(4)) d1 (
    .Clk(Clk), .Reset(Reset), .bus(ifa)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_stall_ctrl #(.LD_STALL(2), .MD_LAT(4)) d2 (
    .Clk(Clk), .Reset(Reset), .bus(ifb)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc2), .flush_count(fc2)
`endif
  );

  // {noop, pc_write, ifid_write, ifid_flush, idex_write, state}
  wire [6:0] o1 = {ifa.noop, ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_write, ifa.state};
  wire [6:0] o2 = {ifb.noop, ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_write, ifb.state};

  localparam logic [6:0] E_RUN   = 7'b0110100;
  localparam logic [6:0] E_LU    = 7'b1000100;
  localparam logic [6:0] E_LDST  = 7'b1000101;
  localparam logic [6:0] E_BR    = 7'b1111100;
  localparam logic [6:0] E_MDB   = 7'b0000010;
  localparam logic [6:0] E_RST0  = 7'b1000100;
  localparam logic [6:0] E_RSTMD = 7'b1000110;

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic md, input logic mr, input logic [4:0] ert, input logic br);
    @(negedge Clk);
    ifa.id_rs = rs; ifa.id_rt = rt; ifa.id_uses_rt = urt; ifa.id_md_start = md;
    ifa.ex_memread = mr; ifa.ex_rt = ert; ifa.ex_branch_taken = br;
    ifb.id_rs = rs; ifb.id_rt = rt; ifb.id_uses_rt = urt; ifb.id_md_start = md;
    ifb.ex_memread = mr; ifb.ex_rt = ert; ifb.ex_branch_taken = br;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drv(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Reset = 1'b1;
    drv(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    total++;
    if (o1 !== E_RST0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", o1, E_RST0); end
    Reset = 1'b0;
  endtask

  task automatic test_load_use();
    drv(5'd8, 5'd9, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    total++;
    if (o1 !== E_LU) begin bad++; $display("FAIL lu1_stall got=%b want=%b", o1, E_LU); end
    total++;
    if (o2 !== E_LU) begin bad++; $display("FAIL lu2_stall got=%b want=%b", o2, E_LU); end
    drv(5'd8, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL lu1_resume got=%b want=%b", o1, E_RUN); end
    total++;
    if (o2 !== E_LDST) begin bad++; $display("FAIL lu2_second got=%b want=%b", o2, E_LDST); end
    drv(5'd8, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (o2 !== E_RUN) begin bad++; $display("FAIL lu2_resume got=%b want=%b", o2, E_RUN); end
    // rt match only counts when the ID instruction reads rt
    drv(5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL rt_unused got=%b want=%b", o1, E_RUN); end
    drv(5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    total++;
    if (o1 !== E_LU) begin bad++; $display("FAIL rt_used got=%b want=%b", o1, E_LU); end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_branch_priority();
    drv(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
    total++;
    if (o2 !== E_BR) begin bad++; $display("FAIL br_over_lu got=%b want=%b", o2, E_BR); end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (o2 !== E_RUN) begin bad++; $display("FAIL br_stays_run got=%b want=%b", o2, E_RUN); end
  endtask

  task automatic test_muldiv();
    drv(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL md_issue got=%b want=%b", o1, E_RUN); end
    for (int i = 0; i < 3; i++) begin
      // branch and load-use here must be ignored while EX holds the mul/div
      drv(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, (i == 1));
      total++;
      if (o1 !== E_MDB) begin bad++; $display("FAIL md_busy%0d got=%b want=%b", i, o1, E_MDB); end
    end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL md_done got=%b want=%b", o1, E_RUN); end
  endtask

  task automatic test_zero_reg();
    drv(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL zero_reg got=%b want=%b", o1, E_RUN); end
  endtask

  task automatic test_reset_mid_stall();
    drv(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (o1 !== E_MDB) begin bad++; $display("FAIL rst_pre got=%b want=%b", o1, E_MDB); end
    Reset = 1'b1;
    #1;
    total++;
    if (o1 !== E_RSTMD) begin bad++; $display("FAIL rst_force got=%b want=%b", o1, E_RSTMD); end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    Reset = 1'b0;
    #1;
    total++;
    if (o1 !== E_RUN) begin bad++; $display("FAIL rst_abort got=%b want=%b", o1, E_RUN); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    drv(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    drv(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    drv(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++;
    if (sc1 !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d want=4", sc1); end
    total++;
    if (fc1 !== 32'd1) begin bad++; $display("FAIL perf_flush got=%0d want=1", fc1); end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_muldiv();
    test_zero_reg();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
